// File: rtl/regfile_pkg.sv
// Shared register-file write-port constants and payload type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } regwr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of NUM_REQ writeback sources onto one registered
// register-file write port. Optional bypass outputs under REGWR_FWD_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Flush,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegiter,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      Busy
`ifdef REGWR_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         FwdAddrA,
  input  logic [ADDR_W-1:0]         FwdAddrB,
  output logic                      FwdHitA,
  output logic                      FwdHitB,
  output logic [DATA_W-1:0]         FwdData
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   rr_ptr_d;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic               win_any;
  logic               transfer;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  data_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (ReqValid),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Grant is the only handshake signal; it is gated so it never shows during reset or flush.
  assign ReqReady = (reset || Flush) ? '0 : win_gnt;
  assign transfer = win_any && !Flush && !reset;
  assign addr_sel = ReqAddr[win_idx*ADDR_W +: ADDR_W];
  assign data_sel = ReqData[win_idx*DATA_W +: DATA_W];
  assign rr_ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
  assign Busy     = (state_q == WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      RegWrite     <= 1'b0;
      WriteRegiter <= '0;
      WriteData    <= '0;
    end else begin
      case (state_q)
        IDLE:    if (transfer) state_q <= WRITE;
        WRITE:   if (!transfer) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (transfer) begin
        rr_ptr_q     <= rr_ptr_d;
        WriteRegiter <= addr_sel;
        WriteData    <= data_sel;
        RegWrite     <= (addr_sel != ADDR_W'(REG_ZERO));
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

`ifdef REGWR_FWD_EN
  assign FwdHitA = RegWrite && (FwdAddrA == WriteRegiter) && (FwdAddrA != '0);
  assign FwdHitB = RegWrite && (FwdAddrB == WriteRegiter) && (FwdAddrB != '0);
  assign FwdData = WriteData;
`endif

endmodule
